// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin arbiter in front of a shared bitwise logic unit
// (NOT / ANDN / AND / XOR) with a one-deep registered result slot.
module negate_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [2:0]             rsp_id,
    output logic [15:0]            op_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_ANDN = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;

    logic [PW-1:0]    r_ptr;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [2:0]       r_rsp_id;
    logic [15:0]      r_op_count;

    logic             w_slot_free;
    logic [NREQ-1:0]  w_grant;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_accept;
    logic [PW:0]      w_sum;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic [PW-1:0]    w_ptr_next;

    // The slot can take a new result when empty or being drained this cycle.
    // Gating with resetn keeps every grant low while reset is held, since the
    // cleared result register would otherwise look free.
    assign w_slot_free = resetn & (~r_rsp_valid | rsp_ready);

    // Round-robin search: first valid requester starting at r_ptr, wrapping.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_accept  = 1'b0;
        w_sum     = '0;
        if (w_slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ)) begin
                    w_sum = w_sum - (PW+1)'(NREQ);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!w_accept && req_valid[i] && (w_sum == (PW+1)'(i))) begin
                        w_grant[i] = 1'b1;
                        w_gnt_idx  = PW'(i);
                        w_accept   = 1'b1;
                    end
                end
            end
        end
    end

    // Operand/opcode mux driven by the one-hot grant.
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op = w_op | req_op[2*i +: 2];
                w_a  = w_a  | req_a[WIDTH*i +: WIDTH];
                w_b  = w_b  | req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Bitwise logic unit; no carries, every bit independent.
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_NOT:  w_result = ~w_a;
            OP_ANDN: w_result = ~w_a & w_b;
            OP_AND:  w_result = w_a & w_b;
            default: w_result = w_a ^ w_b;
        endcase
    end

    assign w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : (w_gnt_idx + 1'b1);

    // Result slot and round-robin pointer; a new accept overwrites a result
    // being consumed in the same cycle, so rsp_valid stays high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else if (w_accept) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_result;
            r_rsp_id    <= 3'(w_gnt_idx);
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_op_count <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_negate_arbiter.sv
// Scoreboard bench for negate_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares on every consuming handshake.
module tb_negate_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [2:0]            rsp_id;
    logic [15:0]           op_count;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    negate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] f_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return ~a & b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = 3'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        resetn    = 1'b0;
        req_valid = '0;
        #3;
        sb.delete();
        cyc();
        resetn = 1'b1;
    endtask

    // Monitor: every consuming handshake must match the oldest expected entry.
    always @(negedge clock) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got id %0d data 0x%08h, expected no response", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_id", 32'(rsp_id), 32'(e.id));
                check("sb_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        logic [31:0] hand_exp [4];
        logic [31:0] a_v;

        resetn    = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, including grant suppression while reset is held
        #2 req_valid = 4'hF;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        cyc();
        cyc();
        resetn = 1'b1;

        // Single NOT from requester 2
        rsp_ready = 1'b1;
        set_req(2, 2'b00, 32'h0000_FFFF, 32'hDEAD_BEEF);
        req_valid = 4'b0100;
        push_exp(2, 32'hFFFF_0000);
        #1 check("single_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_data", rsp_data, 32'hFFFF_0000);
        check("single_id", 32'(rsp_id), 32'd2);
        check("single_cnt0", 32'(op_count), 32'd0);
        cyc();
        check("single_cnt1", 32'(op_count), 32'd1);
        check("single_drain", 32'(rsp_valid), 32'd0);

        // All four opcodes, hand-computed results
        hand_exp[0] = 32'h0F0F_EDCB;
        hand_exp[1] = 32'h0F00_00CB;
        hand_exp[2] = 32'hF000_0034;
        hand_exp[3] = 32'h0FF0_12CB;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 2'(k), 32'hF0F0_1234, 32'hFF00_00FF);
            req_valid = 4'b0001;
            push_exp(0, hand_exp[k]);
            cyc();
        end
        req_valid = '0;
        cyc();
        cyc();

        // Fairness: all requesters valid, grants rotate from ptr 0
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'(i), 32'(32'h1111_1111 * (i + 1)), 32'h0F0F_0F0F);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            int g;
            g = c % 4;
            push_exp(g, f_op(2'(g), 32'(32'h1111_1111 * (g + 1)), 32'h0F0F_0F0F));
            #1 check("fair_ready", 32'(req_ready), 32'(1 << g));
            cyc();
        end
        req_valid = '0;
        cyc();
        check("fair_count", 32'(op_count), 32'd8);

        // Backpressure: result from 1 held, 3 follows with no bubble
        rsp_ready = 1'b0;
        set_req(1, 2'b11, 32'h1234_5678, 32'hFFFF_0000);
        set_req(3, 2'b10, 32'hCAFE_BABE, 32'h0000_FFFF);
        req_valid = 4'b1010;
        push_exp(1, 32'hEDCB_5678);
        #1 check("bp_first_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b1000;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("bp_stall_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_hold_data", rsp_data, 32'hEDCB_5678);
            cyc();
        end
        rsp_ready = 1'b1;
        push_exp(3, 32'h0000_BABE);
        #1 check("bp_release_ready", 32'(req_ready), 32'h8);
        cyc();
        req_valid = '0;
        check("bp_nobubble_valid", 32'(rsp_valid), 32'd1);
        check("bp_nobubble_id", 32'(rsp_id), 32'd3);
        check("bp_count9", 32'(op_count), 32'd9);
        cyc();
        check("bp_count10", 32'(op_count), 32'd10);

        // op_count wrap: 65537 consumed responses
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i <= 65536; i++) begin
            a_v = 32'(i);
            set_req(0, 2'b11, a_v, 32'hA5A5_0000);
            push_exp(0, a_v ^ 32'hA5A5_0000);
            if (i == 65536) check("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
            cyc();
        end
        req_valid = '0;
        cyc();
        check("wrap_one", 32'(op_count), 32'd1);

        // Reset while a result is held and ptr = 2
        rsp_ready = 1'b0;
        set_req(1, 2'b00, 32'h0000_0000, 32'h0000_0000);
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        check("mid_held", 32'(rsp_valid), 32'd1);
        #1;
        resetn    = 1'b0;
        req_valid = 4'b0101;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        cyc();
        cyc();
        resetn    = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 2'b11, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
        set_req(2, 2'b01, 32'h00FF_00FF, 32'hFFFF_FFFF);
        push_exp(0, 32'hF0F0_F0F0);
        #1 check("post_rst_grant0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0100;
        push_exp(2, 32'hFF00_FF00);
        #1 check("post_rst_grant2", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/negate_arbiter.md
# negate_arbiter

Round-robin arbiter and one-deep result register for a shared 32-bit bitwise logic unit. It is built around the bitwise-inversion datapath.

- Several requesters in the miner core share one unit. These are the SHA-256 round engine (Ch = (e&f) ^ (~e&g)), message-schedule logic and control.
- At most one operation is accepted per cycle.
- Each result is registered and held until the consumer takes it.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `WIDTH`, default 32: operand and result width.
- `clock` input 1: rising-edge clock.
- `resetn` input 1: reset, asynchronous assert, active-low, synchronously deasserted externally.
- `req_valid` input NREQ: request valid, one bit per requester.
- `req_ready` output NREQ: grant. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_op` input 2*NREQ: opcode of requester i at bits [2i+1:2i].
- `req_a` input WIDTH*NREQ: operand A of requester i at bits [WIDTH*i +: WIDTH].
- `req_b` input WIDTH*NREQ: operand B, same packing as `req_a`.
- `rsp_valid` output 1: result register holds a result.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output WIDTH: result.
- `rsp_id` output 3: index of the requester that issued the result.
- `op_count` output 16: number of completed responses, counted on `rsp_valid & rsp_ready`. Wraps from 0xFFFF to 0x0000.

## Operation
- Opcodes:
  - 00 NOT: `rsp_data = ~a`, B ignored.
  - 01 ANDN: `~a & b`.
  - 10 AND: `a & b`.
  - 11 XOR: `a ^ b`.
  - All operations are purely bitwise at WIDTH, with no carries.
- State:
  - Round-robin pointer `ptr` (0..NREQ-1).
  - Result register: `rsp_valid`, `rsp_data`, `rsp_id`.
  - `op_count`.
- `slot_free = !rsp_valid | rsp_ready`.
- Grant (combinational):
  - If `slot_free` is 0, all `req_ready` are 0.
  - Otherwise, exactly one `req_ready[i]` is 1: the first i with `req_valid[i]`, searching ptr, ptr+1, … modulo NREQ.
  - No grant is given when no `req_valid` is set.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On an accepted request from requester g:
  - `rsp_data` ← op(a_g, b_g), `rsp_id` ← g, `rsp_valid` ← 1.
  - `ptr` ← (g+1) mod NREQ.
- On `rsp_valid & rsp_ready` with no new accept: `rsp_valid` ← 0. `rsp_data` and `rsp_id` hold their last values.
- Simultaneous consume and accept in the same cycle:
  - The new result replaces the old one.
  - `rsp_valid` stays 1.
  - `op_count` increments once.
- `ptr` changes only on an accept. An idle cycle or a stalled cycle leaves `ptr` unchanged.
- Requester obligation: a requester holding `req_valid` while not granted keeps its operands and opcode stable. The arbiter samples them only in the grant cycle.
- Reset (`resetn` low, asynchronous):
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `ptr` = 0, `op_count` = 0.
  - `req_ready` = 0 while `resetn` is low.
  - A result held when reset asserts is discarded, with no response.
- Unused `rsp_id` bits are 0 when NREQ < 8.

## Timing
- Latency: a request accepted at edge N has its result visible on `rsp_data`/`rsp_valid` after edge N, i.e. in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` = 1 continuously.
- Backpressure:
  - With `rsp_ready` = 0 and `rsp_valid` = 1, no grants are issued.
  - The result stays stable until the cycle in which `rsp_ready` = 1.
- Fairness: with all NREQ requesters continuously valid and no stalls, grants rotate 0,1,…,NREQ-1,0,…. Each requester waits at most NREQ-1 grants.
- `op_count` updates at the same edge as the consuming handshake.

## Test plan
- Reset then single op:
  - Stimulus: requester 2 sends NOT with a = 0x0000_FFFF, `rsp_ready` = 1.
  - Required response: `req_ready` = 0b0100 in the same cycle. Next cycle `rsp_valid` = 1, `rsp_data` = 0xFFFF_0000, `rsp_id` = 2, `op_count` = 1 one cycle later.
- All opcodes:
  - Stimulus: a = 0xF0F0_1234, b = 0xFF00_00FF.
  - Required responses: NOT → 0x0F0F_EDCB, ANDN → 0x0F00_00CB, AND → 0xF000_0034, XOR → 0x0FF0_12CB.
- Fairness:
  - Stimulus: all 4 requesters valid for 8 cycles, `rsp_ready` = 1.
  - Required response: `rsp_id` sequence 0,1,2,3,0,1,2,3. `op_count` = 8 after draining.
- Backpressure:
  - Stimulus: hold `rsp_ready` = 0 for 5 cycles with requesters 1 and 3 valid.
  - Required response: one result held stable (`rsp_id` = 1). `req_ready` = 0 throughout. After release, `rsp_id` = 3 follows with no bubble.
- Wrap-around:
  - Stimulus: force 65 537 consumed responses.
  - Required response: `op_count` = 0x0001.
- Reset mid-operation:
  - Stimulus: assert `resetn` low while `rsp_valid` = 1 and `ptr` = 2.
  - Required response: outputs clear immediately with no clock edge. After release, with requesters 0 and 2 valid, requester 0 is granted first.
